// File: rtl/pulse_meter_pkg.sv
// ============================================================================
// Module : pulse_meter_pkg
// Brief  : Shared constants and FSM encoding for the pulse meter/generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_meter_pkg;

  localparam int          c_CNT_W       = 25;
  localparam int unsigned c_TIMEOUT     = 24_999_999;
  localparam int          c_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOW  = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_HIGH      = 3'd3,
    S_LOW       = 3'd4,
    S_DONE      = 3'd5
  } meter_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_meter_edge_sync.sv
// ============================================================================
// Module : edge_sync
// Brief  : Flop-chain synchroniser with single-cycle rise/fall detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_sync_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_chain  <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_chain  <= {r_chain[SYNC_STAGES-2:0], din};
      r_sync_d <= r_chain[SYNC_STAGES-1];
    end
  end

  assign sync = r_chain[SYNC_STAGES-1];
  assign rise =  sync & ~r_sync_d;
  assign fall = ~sync &  r_sync_d;

endmodule

`default_nettype wire

// File: rtl/pulse_meter.sv
// ============================================================================
// Module : pulse_meter
// Brief  : Single-shot high-width and rise-to-rise period measurement.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int          CNT_W       = c_CNT_W,
  parameter int unsigned TIMEOUT     = c_TIMEOUT,
  parameter int          SYNC_STAGES = c_SYNC_STAGES
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             arm,
  input  logic             pulse_in,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_timeout
);

  localparam logic [CNT_W-1:0] c_TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  meter_state_t     r_state;
  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_wcap;
  logic             w_sync;
  logic             w_rise;
  logic             w_fall;
  logic             w_tmo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + c_ONE;
  endfunction

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (pulse_in),
    .sync    (w_sync),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  // Only the four waiting states can expire; DONE always leaves next cycle.
  assign w_tmo = (r_state inside {S_WAIT_LOW, S_WAIT_RISE, S_HIGH, S_LOW}) &&
                 (r_tmr == c_TMO);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_wcnt       <= '0;
      r_pcnt       <= '0;
      r_wcap       <= '0;
      busy         <= 1'b0;
      meas_valid   <= 1'b0;
      meas_width   <= '0;
      meas_period  <= '0;
      meas_timeout <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (r_state != S_IDLE) r_tmr <= r_tmr + c_ONE;

      if (w_tmo) begin
        r_state      <= S_DONE;
        r_tmr        <= '0;
        busy         <= 1'b0;
        meas_valid   <= 1'b1;
        meas_timeout <= 1'b1;
        meas_width   <= '0;
        meas_period  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Arming mid-pulse first waits for the low phase.
            if (arm) begin
              r_tmr   <= '0;
              busy    <= 1'b1;
              r_state <= w_sync ? S_WAIT_LOW : S_WAIT_RISE;
            end
          end
          S_WAIT_LOW: begin
            if (w_fall) begin
              r_tmr   <= '0;
              r_state <= S_WAIT_RISE;
            end
          end
          S_WAIT_RISE: begin
            if (w_rise) begin
              r_tmr   <= '0;
              r_wcnt  <= c_ONE;
              r_pcnt  <= c_ONE;
              r_state <= S_HIGH;
            end
          end
          S_HIGH: begin
            r_pcnt <= sat_inc(r_pcnt);
            if (w_fall) begin
              r_tmr   <= '0;
              r_wcap  <= r_wcnt;
              r_state <= S_LOW;
            end else begin
              r_wcnt <= sat_inc(r_wcnt);
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_tmr        <= '0;
              busy         <= 1'b0;
              meas_valid   <= 1'b1;
              meas_timeout <= 1'b0;
              meas_width   <= r_wcap;
              meas_period  <= r_pcnt;
              r_state      <= S_DONE;
            end else begin
              r_pcnt <= sat_inc(r_pcnt);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
